mcpu_mem_ltc_arb: RTL and testbench

MCPU_MEM_LTC_ARB -- requirements
Module: mcpu_mem_ltc_arb

---
 rtl/mcpu_mem_ltc_arb.sv | 114 +++++++++++
 tb/tb_mcpu_mem_ltc_arb.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_mem_ltc_arb.sv
// Round-robin arbiter from NPORTS requesters onto one registered LTC command port.
// In-order responses are routed back to their requester through a tag FIFO.
module mcpu_mem_ltc_arb #(
    parameter int NPORTS      = 4,
    parameter int OUTSTANDING = 8
) (
    input  logic                  clkrst_mem_clk,
    input  logic                  clkrst_mem_rst,
    input  logic                  boot_done,
    input  logic [NPORTS-1:0]     req_valid,
    input  logic [3*NPORTS-1:0]   req_opcode,
    input  logic [27*NPORTS-1:0]  req_addr,
    input  logic [256*NPORTS-1:0] req_wdata,
    input  logic [32*NPORTS-1:0]  req_wbe,
    output logic [NPORTS-1:0]     req_stall,
    output logic [NPORTS-1:0]     req_rvalid,
    output logic [255:0]          req_rdata,
    output logic                  arb2ltc_valid,
    output logic [2:0]            arb2ltc_opcode,
    output logic [26:0]           arb2ltc_addr,
    output logic [255:0]          arb2ltc_wdata,
    output logic [31:0]           arb2ltc_wbe,
    input  logic                  ltc2arb_stall,
    input  logic                  ltc2arb_rvalid,
    input  logic [255:0]          ltc2arb_rdata,
    output logic                  arb_err
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int AW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     winner;
    logic              found;
    logic [NPORTS-1:0] eligible;
    logic              load;
    logic              pop;
    logic              full;
    logic              empty;
    logic [PW-1:0]     tags [OUTSTANDING];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    assign full  = (count == CW'(OUTSTANDING));
    assign empty = (count == '0);

    // Before boot completes only the preloader on port 0 may win.
    assign eligible = req_valid
                    & (boot_done ? {NPORTS{1'b1}} : NPORTS'(1))
                    & {NPORTS{~full}};

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = (int'(rr_ptr) + k) % NPORTS;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    assign load = found & ~ltc2arb_stall;
    assign pop  = ltc2arb_rvalid & ~empty;

    assign req_stall  = load ? ~(NPORTS'(1) << winner) : {NPORTS{1'b1}};
    assign req_rvalid = pop ? (NPORTS'(1) << tags[rd_ptr]) : '0;
    assign req_rdata  = ltc2arb_rdata;

    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            arb2ltc_valid  <= 1'b0;
            arb2ltc_opcode <= '0;
            arb2ltc_addr   <= '0;
            arb2ltc_wdata  <= '0;
            arb2ltc_wbe    <= '0;
            rr_ptr         <= PW'(NPORTS - 1);
        end else if (!ltc2arb_stall) begin
            arb2ltc_valid <= found;
            if (found) begin
                arb2ltc_opcode <= req_opcode[3*int'(winner) +: 3];
                arb2ltc_addr   <= req_addr[27*int'(winner) +: 27];
                arb2ltc_wdata  <= req_wdata[256*int'(winner) +: 256];
                arb2ltc_wbe    <= req_wbe[32*int'(winner) +: 32];
                rr_ptr         <= winner;
            end
        end
    end

    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            arb_err <= 1'b0;
        end else begin
            if (load) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CW'(load) - CW'(pop);
            arb_err <= arb_err | (ltc2arb_rvalid & empty);
        end
    end

    // Tag storage needs no reset; validity is tracked by count.
    always_ff @(posedge clkrst_mem_clk) begin
        if (load) tags[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_mcpu_mem_ltc_arb.sv
// Bench for mcpu_mem_ltc_arb: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_mcpu_mem_ltc_arb;

    localparam int NP  = 4;
    localparam int OUT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            boot_done = 1'b0;
    logic [NP-1:0]   req_valid = '0;
    logic [3*NP-1:0] req_opcode;
    logic [27*NP-1:0] req_addr;
    logic [256*NP-1:0] req_wdata;
    logic [32*NP-1:0] req_wbe;
    logic [NP-1:0]   req_stall;
    logic [NP-1:0]   req_rvalid;
    logic [255:0]    req_rdata;
    logic            arb2ltc_valid;
    logic [2:0]      arb2ltc_opcode;
    logic [26:0]     arb2ltc_addr;
    logic [255:0]    arb2ltc_wdata;
    logic [31:0]     arb2ltc_wbe;
    logic            ltc_stall = 1'b0;
    logic            ltc_rvalid = 1'b0;
    logic [255:0]    ltc_rdata = '0;
    logic            arb_err;

    logic [2:0]   p_op   [NP];
    logic [26:0]  p_addr [NP];
    logic [255:0] p_wd   [NP];
    logic [31:0]  p_be   [NP];

    // Behavioural model state
    logic         m_valid;
    logic [2:0]   m_op;
    logic [26:0]  m_addr;
    logic [255:0] m_wd;
    logic [31:0]  m_be;
    int           m_rr;
    int           tagq[$];
    logic         m_err;
    int           m_win;
    logic         m_load;

    int n_cmp = 0;
    int n_bad = 0;

    mcpu_mem_ltc_arb #(.NPORTS(NP), .OUTSTANDING(OUT)) dut (
        .clkrst_mem_clk (clk),
        .clkrst_mem_rst (rst),
        .boot_done      (boot_done),
        .req_valid      (req_valid),
        .req_opcode     (req_opcode),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wbe        (req_wbe),
        .req_stall      (req_stall),
        .req_rvalid     (req_rvalid),
        .req_rdata      (req_rdata),
        .arb2ltc_valid  (arb2ltc_valid),
        .arb2ltc_opcode (arb2ltc_opcode),
        .arb2ltc_addr   (arb2ltc_addr),
        .arb2ltc_wdata  (arb2ltc_wdata),
        .arb2ltc_wbe    (arb2ltc_wbe),
        .ltc2arb_stall  (ltc_stall),
        .ltc2arb_rvalid (ltc_rvalid),
        .ltc2arb_rdata  (ltc_rdata),
        .arb_err        (arb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic pack();
        for (int i = 0; i < NP; i++) begin
            req_opcode[3*i +: 3]    = p_op[i];
            req_addr[27*i +: 27]    = p_addr[i];
            req_wdata[256*i +: 256] = p_wd[i];
            req_wbe[32*i +: 32]     = p_be[i];
        end
    endtask

    task automatic new_cmd(input int i, input logic v);
        req_valid[i] = v;
        p_op[i]   = 3'($urandom);
        p_addr[i] = 27'($urandom);
        p_wd[i]   = rand256();
        p_be[i]   = $urandom;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_op    = '0;
        m_addr  = '0;
        m_wd    = '0;
        m_be    = '0;
        m_rr    = NP - 1;
        tagq.delete();
        m_err   = 1'b0;
        m_load  = 1'b0;
        m_win   = 0;
    endtask

    // Settle, predict this cycle's combinational behaviour, compare everything.
    task automatic eval();
        logic          found;
        logic [NP-1:0] exp_stall;
        logic [NP-1:0] exp_rv;
        pack();
        #1;
        if (rst) begin
            model_reset();
        end else begin
            found = 1'b0;
            m_win = 0;
            if (tagq.size() < OUT) begin
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (m_rr + k) % NP;
                    if (!found && req_valid[p] && (boot_done || p == 0)) begin
                        found = 1'b1;
                        m_win = p;
                    end
                end
            end
            m_load    = found && !ltc_stall;
            exp_stall = '1;
            if (m_load) exp_stall[m_win] = 1'b0;
            exp_rv = '0;
            if (ltc_rvalid && tagq.size() > 0) exp_rv[tagq[0]] = 1'b1;
            check("req_stall", 256'(req_stall), 256'(exp_stall));
            check("req_rvalid", 256'(req_rvalid), 256'(exp_rv));
            if (exp_rv != 0) check("req_rdata", req_rdata, ltc_rdata);
        end
        check("arb2ltc_valid", 256'(arb2ltc_valid), 256'(m_valid));
        check("arb2ltc_opcode", 256'(arb2ltc_opcode), 256'(m_op));
        check("arb2ltc_addr", 256'(arb2ltc_addr), 256'(m_addr));
        check("arb2ltc_wdata", arb2ltc_wdata, m_wd);
        check("arb2ltc_wbe", 256'(arb2ltc_wbe), 256'(m_be));
        check("arb_err", 256'(arb_err), 256'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (ltc_rvalid) begin
                if (tagq.size() > 0) void'(tagq.pop_front());
                else m_err = 1'b1;
            end
            if (!ltc_stall) begin
                m_valid = m_load;
                if (m_load) begin
                    m_op   = p_op[m_win];
                    m_addr = p_addr[m_win];
                    m_wd   = p_wd[m_win];
                    m_be   = p_be[m_win];
                    m_rr   = m_win;
                    tagq.push_back(m_win);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eval();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            p_op[i]   = 3'(i + 1);
            p_addr[i] = 27'(100 + i);
            p_wd[i]   = {8{32'(i)}};
            p_be[i]   = 32'hF << i;
        end
        model_reset();
        @(negedge clk);

        // Reset values
        rst = 1'b1;
        eval();
        check("rst_valid", 256'(arb2ltc_valid), 256'(0));
        check("rst_wbe", 256'(arb2ltc_wbe), 256'(0));
        check("rst_err", 256'(arb_err), 256'(0));
        tick();
        rst = 1'b0;

        // Boot gate: only port 0 wins
        boot_done = 1'b0;
        req_valid = 4'b1111;
        eval();
        check("boot_stall0", 256'(req_stall), 256'(4'b1110));
        tick();
        eval();
        check("boot_stall1", 256'(req_stall), 256'(4'b1110));
        check("boot_addr", 256'(arb2ltc_addr), 256'(27'd100));
        tick();

        // Round robin continues from port 0
        boot_done = 1'b1;
        eval();
        check("rr_stall1", 256'(req_stall), 256'(4'b1101));
        tick();
        eval();
        check("rr_addr1", 256'(arb2ltc_addr), 256'(27'd101));
        check("rr_stall2", 256'(req_stall), 256'(4'b1011));
        tick();
        eval();
        check("rr_addr2", 256'(arb2ltc_addr), 256'(27'd102));
        check("rr_stall3", 256'(req_stall), 256'(4'b0111));
        tick();

        // Spurious response after a reset discards outstanding tags
        req_valid = '0;
        do_reset();
        ltc_rvalid = 1'b1;
        eval();
        check("spur_rvalid", 256'(req_rvalid), 256'(0));
        tick();
        ltc_rvalid = 1'b0;
        eval();
        check("spur_err", 256'(arb_err), 256'(1));
        tick();

        // FIFO full
        do_reset();
        req_valid = 4'b1000;
        for (int n = 0; n < OUT; n++) begin
            eval();
            tick();
        end
        eval();
        check("full_stall", 256'(req_stall), 256'(4'b1111));
        tick();
        ltc_rvalid = 1'b1;
        eval();
        check("full_valid", 256'(arb2ltc_valid), 256'(0));
        check("full_rvalid", 256'(req_rvalid), 256'(4'b1000));
        check("full_pop_stall", 256'(req_stall), 256'(4'b1111));
        tick();
        ltc_rvalid = 1'b0;
        eval();
        check("full_resume", 256'(req_stall), 256'(4'b0111));
        tick();

        // LTC backpressure holds outputs
        req_valid = '0;
        do_reset();
        req_valid = 4'b0001;
        eval();
        tick();
        p_addr[0] = 27'd200;
        ltc_stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            eval();
            check("bp_stall", 256'(req_stall), 256'(4'b1111));
            check("bp_addr", 256'(arb2ltc_addr), 256'(27'd100));
            tick();
        end
        ltc_stall = 1'b0;
        eval();
        check("bp_resume", 256'(req_stall), 256'(4'b1110));
        tick();
        eval();
        check("bp_addr2", 256'(arb2ltc_addr), 256'(27'd200));
        tick();

        // Response routing: port 2 then port 1
        req_valid = '0;
        do_reset();
        req_valid = 4'b0100;
        eval();
        tick();
        req_valid = 4'b0010;
        eval();
        tick();
        req_valid = '0;
        ltc_rvalid = 1'b1;
        ltc_rdata = {32{8'hAA}};
        eval();
        check("route_rv2", 256'(req_rvalid), 256'(4'b0100));
        check("route_data", req_rdata, {32{8'hAA}});
        tick();
        ltc_rdata = {32{8'h55}};
        eval();
        check("route_rv1", 256'(req_rvalid), 256'(4'b0010));
        tick();
        ltc_rvalid = 1'b0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!req_valid[i] || (m_load && m_win == i))
                    new_cmd(i, ($urandom % 100) < 65);
            end
            if (rst) rst = 1'b0;
            else rst = ($urandom % 500) == 0;
            if (($urandom % 60) == 0) boot_done = ~boot_done;
            ltc_stall  = ($urandom % 4) == 0;
            ltc_rvalid = (tagq.size() > 0) ? 1'($urandom % 2)
                                           : (($urandom % 50) == 0);
            ltc_rdata  = rand256();
            eval();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
